fabric_cfg_loader: RTL



---
 rtl/fabric_cfg_pkg.sv | 7 +
 rtl/cfg_word_serializer.sv | 58 +++++
 rtl/fabric_cfg_loader.sv | 86 ++++++++
 3 files changed

// File: rtl/fabric_cfg_pkg.sv
// fabric_cfg_pkg: shared loader state encoding and chain-length helper
package fabric_cfg_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SETTLE, ST_DONE} state_e;
  function automatic int cfg_chain_bits(input int num_luts, input int ws, input int wd, input int tiles);
    return tiles * num_luts * (1 << ws) * wd;
  endfunction
endpackage

// File: rtl/cfg_word_serializer.sv
// cfg_word_serializer: two-deep word buffer feeding an LSB-first bit stream
module cfg_word_serializer #(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic [WORD_W-1:0] w_data,
  input  logic              w_valid,
  output logic              w_ready,
  output logic              bit_o,
  output logic              bit_valid,
  input  logic              bit_take
);
  localparam int CW = $clog2(WORD_W + 1);
  logic [WORD_W-1:0] hold_q, hold_d, sr_q, sr_d;
  logic              hold_v_q, hold_v_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              acc, empty;
  assign w_ready   = !hold_v_q || cnt_q == '0;
  assign acc       = w_valid && w_ready;
  assign empty     = cnt_q == '0 || (bit_take && cnt_q == CW'(1));
  assign bit_o     = sr_q[0];
  assign bit_valid = cnt_q != '0;
  // refill the shifter from hold (or the input) on the edge it empties so shifting stays gap-free
  always_comb begin
    hold_d   = hold_q;
    hold_v_d = hold_v_q;
    sr_d     = bit_take ? sr_q >> 1 : sr_q;
    cnt_d    = cnt_q - CW'(bit_take);
    if (empty && hold_v_q) begin
      sr_d     = hold_q;
      cnt_d    = CW'(WORD_W);
      hold_d   = w_data;
      hold_v_d = acc;
    end else if (empty && acc) begin
      sr_d  = w_data;
      cnt_d = CW'(WORD_W);
    end else if (acc) begin
      hold_d   = w_data;
      hold_v_d = 1'b1;
    end
  end
  // buffer registers, flushed by reset or by the controller
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      hold_q   <= '0;
      hold_v_q <= 1'b0;
      sr_q     <= '0;
      cnt_q    <= '0;
    end else begin
      hold_q   <= hold_d;
      hold_v_q <= hold_v_d;
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: rtl/fabric_cfg_loader.sv
// fabric_cfg_loader: streams host bitstream words onto the tile configuration chain
module fabric_cfg_loader
  import fabric_cfg_pkg::*;
#(
  parameter int WORD_W     = 32,
  parameter int CHAIN_BITS = 1024,
  parameter int SETTLE     = 4,
  parameter int CNT_W      = $clog2(CHAIN_BITS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              chain_bit,
  output logic              chain_set,
  output logic              fabric_cen,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bits_left
);
  localparam int SW = $clog2(SETTLE + 1);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] bits_left_q, bits_left_d, acc_left_q, acc_left_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic             go, kill, acc, ser_ready, bit_valid;
  assign busy       = state_q == ST_LOAD || state_q == ST_SETTLE;
  assign fabric_cen = !busy;
  assign done       = state_q == ST_DONE;
  assign bits_left  = bits_left_q;
  assign go         = start && !abort && !busy;
  assign kill       = abort && busy;
  assign cfg_ready  = state_q == ST_LOAD && acc_left_q != '0 && ser_ready;
  assign acc        = cfg_valid && cfg_ready;
  assign chain_set  = state_q == ST_LOAD && bit_valid && bits_left_q != '0;

  cfg_word_serializer #(.WORD_W(WORD_W)) u_ser (
    .clk      (clk),
    .rst      (rst),
    .clr      (go || kill),
    .w_data   (cfg_data),
    .w_valid  (acc),
    .w_ready  (ser_ready),
    .bit_o    (chain_bit),
    .bit_valid(bit_valid),
    .bit_take (chain_set)
  );

  // load sequencing; abort wins over start and over the final-shift exit, and freezes bits_left
  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    bits_left_d = bits_left_q - CNT_W'(chain_set);
    acc_left_d  = !acc ? acc_left_q : int'(acc_left_q) > WORD_W ? acc_left_q - CNT_W'(WORD_W) : '0;
    if (kill) begin
      state_d     = ST_IDLE;
      bits_left_d = bits_left_q;
    end else if (go) begin
      state_d     = ST_LOAD;
      bits_left_d = CNT_W'(CHAIN_BITS);
      acc_left_d  = CNT_W'(CHAIN_BITS);
    end else if (chain_set && bits_left_q == CNT_W'(1)) begin
      state_d  = ST_SETTLE;
      settle_d = SW'(SETTLE - 1);
    end else if (state_q == ST_SETTLE) begin
      state_d  = settle_q == '0 ? ST_DONE : ST_SETTLE;
      settle_d = settle_q - SW'(1);
    end
  end
  // controller state and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bits_left_q <= '0;
      acc_left_q  <= '0;
      settle_q    <= '0;
    end else begin
      state_q     <= state_d;
      bits_left_q <= bits_left_d;
      acc_left_q  <= acc_left_d;
      settle_q    <= settle_d;
    end
  end
endmodule
